// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types used by the program counter block.
//   pcsrc_t : next-PC source select (SEQ, BRANCH, JUMP, JREG)
//   pcst_t  : PC unit run state (RUN, HALTED)
//   PC_STEP : sequential increment in bytes
//   JTGT_HI : first PC bit kept from pc+4 in a J-type target
package cpu_types_pkg;
  typedef enum logic [1:0] {
    SEQ    = 2'd0,
    BRANCH = 2'd1,
    JUMP   = 2'd2,
    JREG   = 2'd3
  } pcsrc_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } pcst_t;

  localparam int PC_STEP = 4;
  localparam int JTGT_HI = 28;
endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: decode/control <-> PC unit bundle.
//   master : decode side, drives the next-PC selects and event strobes
//   slave  : pc_unit, returns pc, pc_plus4, epc, exl, halted
// Optional (PC_ALIGN_CHK_EN): align_fault, badvaddr returned by the slave.
interface pc_unit_if #(parameter int PC_W = 32);
  import cpu_types_pkg::*;

  logic            pc_en;
  pcsrc_t          pc_src;
  logic            branch_taken;
  logic [15:0]     imm16;
  logic [25:0]     jaddr;
  logic [PC_W-1:0] reg_target;
  logic            halt;
  logic            exc_req;
  logic            eret;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] epc;
  logic            exl;
  logic            halted;
`ifdef PC_ALIGN_CHK_EN
  logic            align_fault;
  logic [PC_W-1:0] badvaddr;
`endif

  modport master (
    output pc_en, pc_src, branch_taken, imm16, jaddr, reg_target,
           halt, exc_req, eret,
`ifdef PC_ALIGN_CHK_EN
    input  align_fault, badvaddr,
`endif
    input  pc, pc_plus4, epc, exl, halted
  );

  modport slave (
    input  pc_en, pc_src, branch_taken, imm16, jaddr, reg_target,
           halt, exc_req, eret,
`ifdef PC_ALIGN_CHK_EN
    output align_fault, badvaddr,
`endif
    output pc, pc_plus4, epc, exl, halted
  );
endinterface

// File: rtl/pc_unit_target_calc.sv
// pc_target_calc: combinational next-PC candidates for pc_unit.
//   in  : pc, pc_src, branch_taken, imm16, jaddr, reg_target
//   out : pc_plus4, br_tgt (pc+4 + sext(imm16)<<2),
//         j_tgt ({pc+4[top], jaddr, 00}), next_pc (selected candidate)
// JREG targets always leave here word-aligned; misalignment detection,
// when enabled, is the caller's job.
module pc_target_calc
  import cpu_types_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [PC_W-1:0] pc,
  input  pcsrc_t          pc_src,
  input  logic            branch_taken,
  input  logic [15:0]     imm16,
  input  logic [25:0]     jaddr,
  input  logic [PC_W-1:0] reg_target,
  output logic [PC_W-1:0] pc_plus4,
  output logic [PC_W-1:0] br_tgt,
  output logic [PC_W-1:0] j_tgt,
  output logic [PC_W-1:0] next_pc
);
  logic [PC_W-1:0] br_off;
  logic [PC_W-1:0] jr_tgt;

  assign pc_plus4 = pc + PC_W'(PC_STEP);
  assign br_off   = {{(PC_W-18){imm16[15]}}, imm16, 2'b00};
  assign br_tgt   = pc_plus4 + br_off;
  assign jr_tgt   = reg_target & ~PC_W'(3);

  // A 28-bit PC has no region bits left above the jump field.
  generate
    if (PC_W > JTGT_HI) begin : g_jregion
      assign j_tgt = {pc_plus4[PC_W-1:JTGT_HI], jaddr, 2'b00};
    end else begin : g_jflat
      assign j_tgt = {jaddr, 2'b00};
    end
  endgenerate

  always_comb begin
    next_pc = pc_plus4;
    case (pc_src)
      SEQ:     next_pc = pc_plus4;
      BRANCH:  next_pc = branch_taken ? br_tgt : pc_plus4;
      JUMP:    next_pc = j_tgt;
      JREG:    next_pc = jr_tgt;
      default: next_pc = pc_plus4;
    endcase
  end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with next-PC selection, stall gating, sticky
// halt and single-level exception entry/return (EPC + EXL).
//   CLK, nRST : clock (rising edge), asynchronous active-low reset
//   bus       : pc_unit_if.slave -- selects/strobes in; pc, pc_plus4,
//               epc, exl, halted out
// Optional build macro PC_ALIGN_CHK_EN: a misaligned JREG (exl=0) enters
// the exception vector instead, pulses align_fault for one cycle and
// captures the offending address in badvaddr.
module pc_unit
  import cpu_types_pkg::*;
#(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_VEC = PC_W'(32'h0000_0000),
  parameter logic [PC_W-1:0] EXC_VEC   = PC_W'(32'h0000_0080)
) (
  input logic       CLK,
  input logic       nRST,
  pc_unit_if.slave  bus
);
  pcst_t           st_q, st_n;
  logic [PC_W-1:0] pc_q, pc_n;
  logic [PC_W-1:0] epc_q, epc_n;
  logic            exl_q, exl_n;
  logic [PC_W-1:0] pc_plus4, br_tgt, j_tgt, next_pc;
`ifdef PC_ALIGN_CHK_EN
  logic            fault_q, fault_n;
  logic [PC_W-1:0] bva_q, bva_n;
`endif

  pc_target_calc #(.PC_W(PC_W)) u_calc (
    .pc           (pc_q),
    .pc_src       (bus.pc_src),
    .branch_taken (bus.branch_taken),
    .imm16        (bus.imm16),
    .jaddr        (bus.jaddr),
    .reg_target   (bus.reg_target),
    .pc_plus4     (pc_plus4),
    .br_tgt       (br_tgt),
    .j_tgt        (j_tgt),
    .next_pc      (next_pc)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      st_q    <= RUN;
      pc_q    <= RESET_VEC;
      epc_q   <= '0;
      exl_q   <= 1'b0;
`ifdef PC_ALIGN_CHK_EN
      fault_q <= 1'b0;
      bva_q   <= '0;
`endif
    end else begin
      st_q    <= st_n;
      pc_q    <= pc_n;
      epc_q   <= epc_n;
      exl_q   <= exl_n;
`ifdef PC_ALIGN_CHK_EN
      fault_q <= fault_n;
      bva_q   <= bva_n;
`endif
    end
  end

  // Priority chain; the order of the if/else arms is the priority order.
  // HALTED falls through with everything held.
  always_comb begin
    st_n    = st_q;
    pc_n    = pc_q;
    epc_n   = epc_q;
    exl_n   = exl_q;
`ifdef PC_ALIGN_CHK_EN
    fault_n = 1'b0;
    bva_n   = bva_q;
`endif
    if (st_q == RUN) begin
      if (bus.exc_req && !exl_q) begin
        // Exception entry wins even while stalled.
        epc_n = pc_q;
        pc_n  = EXC_VEC;
        exl_n = 1'b1;
      end else if (bus.eret && exl_q && bus.pc_en) begin
        pc_n  = epc_q;
        exl_n = 1'b0;
      end else if (bus.halt && bus.pc_en) begin
        // PC stays on the halt instruction.
        st_n = HALTED;
      end else if (bus.pc_en) begin
`ifdef PC_ALIGN_CHK_EN
        if (bus.pc_src == JREG && bus.reg_target[1:0] != 2'b00 && !exl_q) begin
          epc_n   = pc_q;
          pc_n    = EXC_VEC;
          exl_n   = 1'b1;
          fault_n = 1'b1;
          bva_n   = bus.reg_target;
        end else begin
          pc_n = next_pc;
        end
`else
        pc_n = next_pc;
`endif
      end
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_plus4 = pc_plus4;
  assign bus.epc      = epc_q;
  assign bus.exl      = exl_q;
  assign bus.halted   = (st_q == HALTED);
`ifdef PC_ALIGN_CHK_EN
  assign bus.align_fault = fault_q;
  assign bus.badvaddr    = bva_q;
`endif
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed-vector bench for pc_unit (PC_W=32, default vectors).
// Inputs change 1 time unit after each rising edge; outputs are checked
// in the same window, so each check sees the result of the preceding edge.
module tb_pc_unit;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST;
  int   n_vec = 0;
  int   n_err = 0;

  pc_unit_if #(.PC_W(32)) bus ();

  pc_unit #(.PC_W(32)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Loads an arbitrary PC through a JREG.
  task automatic load(input logic [31:0] v);
    bus.pc_en      = 1'b1;
    bus.pc_src     = JREG;
    bus.reg_target = v;
    step();
    bus.pc_src     = SEQ;
  endtask

  initial begin
    nRST             = 1'b0;
    bus.pc_en        = 1'b0;
    bus.pc_src       = SEQ;
    bus.branch_taken = 1'b0;
    bus.imm16        = '0;
    bus.jaddr        = '0;
    bus.reg_target   = '0;
    bus.halt         = 1'b0;
    bus.exc_req      = 1'b0;
    bus.eret         = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_pc",     bus.pc, 32'h0);
    chk("rst_epc",    bus.epc, 32'h0);
    chk("rst_exl",    {31'b0, bus.exl}, 32'h0);
    chk("rst_halted", {31'b0, bus.halted}, 32'h0);

    // Sequential run and stall
    nRST = 1'b1;
    bus.pc_en = 1'b1;
    chk("seq0", bus.pc, 32'h0);
    step(); chk("seq1", bus.pc, 32'h4);
    step(); chk("seq2", bus.pc, 32'h8);
    step(); chk("seq3", bus.pc, 32'hC);
    chk("pc_plus4", bus.pc_plus4, 32'h10);
    bus.pc_en = 1'b0;
    step(); chk("stall", bus.pc, 32'hC);

    // Branch taken / not taken
    load(32'h100); chk("ld100", bus.pc, 32'h100);
    bus.pc_src = BRANCH; bus.imm16 = 16'hFFFE; bus.branch_taken = 1'b1;
    step(); chk("br_taken", bus.pc, 32'h0FC);
    load(32'h100);
    bus.pc_src = BRANCH; bus.branch_taken = 1'b0;
    step(); chk("br_nt", bus.pc, 32'h104);
    bus.pc_src = SEQ;

    // Jump and jump-register
    load(32'h1000_0000);
    bus.pc_src = JUMP; bus.jaddr = 26'h0000040;
    step(); chk("jump", bus.pc, 32'h1000_0100);
    load(32'h400); chk("jreg", bus.pc, 32'h400);

    // Exception entry, ignored nesting, return
    load(32'h200);
    bus.exc_req = 1'b1;
    step();
    chk("exc_pc",  bus.pc, 32'h80);
    chk("exc_epc", bus.epc, 32'h200);
    chk("exc_exl", {31'b0, bus.exl}, 32'h1);
    step();
    chk("exc_nest_pc",  bus.pc, 32'h84);
    chk("exc_nest_epc", bus.epc, 32'h200);
    bus.exc_req = 1'b0; bus.eret = 1'b1;
    step();
    chk("eret_pc",  bus.pc, 32'h200);
    chk("eret_exl", {31'b0, bus.exl}, 32'h0);
    step(); chk("eret_noexl_seq", bus.pc, 32'h204);
    bus.eret = 1'b0;

    // Exception while stalled; eret must wait for pc_en
    bus.pc_en = 1'b0; bus.exc_req = 1'b1;
    step();
    chk("stall_exc_pc", bus.pc, 32'h80);
    chk("stall_exc_epc", bus.epc, 32'h204);
    bus.exc_req = 1'b0; bus.eret = 1'b1;
    step();
    chk("stall_eret_pc",  bus.pc, 32'h80);
    chk("stall_eret_exl", {31'b0, bus.exl}, 32'h1);
    bus.pc_en = 1'b1;
    step();
    chk("eret_go_pc", bus.pc, 32'h204);
    bus.eret = 1'b0;

    // Halt is sticky until reset
    load(32'h40);
    bus.halt = 1'b1;
    step();
    chk("halt_flag", {31'b0, bus.halted}, 32'h1);
    chk("halt_pc",   bus.pc, 32'h40);
    bus.halt = 1'b0; bus.exc_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("halt_hold_pc",  bus.pc, 32'h40);
      chk("halt_hold_exl", {31'b0, bus.exl}, 32'h0);
    end
    bus.exc_req = 1'b0;
    #2 nRST = 1'b0;
    #1;
    chk("halt_rst_pc",     bus.pc, 32'h0);
    chk("halt_rst_halted", {31'b0, bus.halted}, 32'h0);
    @(posedge CLK);
    #1 nRST = 1'b1;

    // Wrap at top of address space, jump region bits
    load(32'hFFFF_FFFC); chk("ld_top", bus.pc, 32'hFFFF_FFFC);
    step(); chk("wrap", bus.pc, 32'h0);
    load(32'hF000_0000);
    bus.pc_src = JUMP; bus.jaddr = 26'h3FF_FFFF;
    step(); chk("jump_hi", bus.pc, 32'hFFFF_FFFC);
    bus.pc_src = SEQ;

    // Misaligned JREG
    load(32'h203);
`ifdef PC_ALIGN_CHK_EN
    chk("al_pc",    bus.pc, 32'h80);
    chk("al_fault", {31'b0, bus.align_fault}, 32'h1);
    chk("al_bva",   bus.badvaddr, 32'h203);
    chk("al_epc",   bus.epc, 32'hFFFF_FFFC);
    chk("al_exl",   {31'b0, bus.exl}, 32'h1);
    step();
    chk("al_pulse", {31'b0, bus.align_fault}, 32'h0);
    chk("al_seq",   bus.pc, 32'h84);
    load(32'h203);
    chk("al_exl_mask",  bus.pc, 32'h200);
    chk("al_exl_nofault", {31'b0, bus.align_fault}, 32'h0);
`else
    chk("al_mask", bus.pc, 32'h200);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised successor to the single-register program counter.
- Owns the PC register and computes its own next PC: sequential, branch, jump and jump-register targets.
- Adds a sticky halt state, stall gating, and a MIPS-style exception entry/return path (EPC, EXL flag).
- Sits between the control/datapath decode logic and the instruction memory address port.

Parameters:
- PC_W, 32, PC width in bits; legal range PC_W >= 28.
- RESET_VEC, 32'h0000_0000 (PC_W bits), PC value loaded on reset.
- EXC_VEC, 32'h0000_0080 (PC_W bits), PC value loaded on exception entry.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- pc_en  in  1  advance enable; 0 = stall (PC holds).
- pc_src  in  2  pcsrc_t: SEQ=0, BRANCH=1, JUMP=2, JREG=3.
- branch_taken  in  1  qualifies BRANCH; 0 behaves as SEQ.
- imm16  in  16  branch word offset.
- jaddr  in  26  jump target field.
- reg_target  in  PC_W  jump-register target (rs value).
- halt  in  1  halt instruction retiring.
- exc_req  in  1  exception request.
- eret  in  1  exception return.
- pc  out  PC_W  current PC.
- pc_plus4  out  PC_W  pc+4, combinational from pc.
- epc  out  PC_W  saved exception PC.
- exl  out  1  exception-level flag.
- halted  out  1  1 while in HALTED.

Behaviour:
- Reset (async, nRST=0): pc=RESET_VEC, epc=0, exl=0, state=RUN, halted=0. Reset wins over every other input at any time, including mid-exception or in HALTED.
- Arithmetic is modulo 2^PC_W; wrap-around at the top of the address space is silent.
  - pc_plus4 = pc + 4.
  - Branch target = pc_plus4 + (sign_extend(imm16) << 2).
  - Jump target = {pc_plus4[PC_W-1:28], jaddr, 2'b00}; when PC_W=28 this is {jaddr, 2'b00}.
  - JREG target = reg_target.
- State machine, pcst_t:
  - RUN -> HALTED on a rising edge with halt=1 and pc_en=1 (and no exc_req taken). pc does not update on that edge.
  - HALTED -> RUN only via reset. In HALTED, all of pc, epc and exl freeze, and all inputs are ignored.
- Per-edge priority in RUN, highest first:
  - 1. exc_req=1 and exl=0: epc<=pc, pc<=EXC_VEC, exl<=1. Taken regardless of pc_en, halt, eret.
  - 2. exc_req=1 and exl=1: request ignored; fall through to the rules below (no nesting).
  - 3. eret=1 and exl=1 and pc_en=1: pc<=epc, exl<=0. eret with exl=0 is treated as SEQ.
  - 4. halt=1 and pc_en=1: enter HALTED as above.
  - 5. pc_en=0: pc holds. Non-exception state holds too; only rule 1 can act while stalled.
  - 6. Otherwise pc<=selected target per pc_src. BRANCH with branch_taken=0 selects pc_plus4.
- Latency: one cycle from the select inputs to the new pc; pc_plus4 follows pc combinationally in the same cycle.
- Alignment without the optional feature: the JREG target's low 2 bits are forced to 00.

Optional Feature:
- Macro: PC_ALIGN_CHK_EN.
- Defined:
  - A JREG whose reg_target[1:0] != 0 is converted into an exception (epc<=pc, pc<=EXC_VEC, exl<=1), provided exl=0.
  - Adds output align_fault (1 bit, one-cycle pulse, reset 0) and output badvaddr (PC_W bits, reset 0), which captures reg_target.
  - If exl=1, the fault is dropped and the target is masked to 00.
- Undefined: the ports are absent; the low 2 bits are always masked to 00.

Decomposition:
- Add to cpu_types_pkg:
  - pcsrc_t enum (2 bits).
  - pcst_t enum (RUN, HALTED).
  - Constants PC_STEP=4 and JTGT_HI=28.
- One natural sub-module: pc_target_calc, purely combinational, parametrised by PC_W. It computes pc_plus4, the branch target, the jump target and the selected next PC.
- The PC, EPC, exl and state registers stay in pc_unit.

Test Plan:
- Reset/seq: nRST low then high, pc_en=1, SEQ for 3 cycles -> pc = 0x0, 0x4, 0x8, 0xC; pc_en=0 one cycle -> pc stays 0xC.
- Branch: pc=0x100, BRANCH, imm16=0xFFFE, taken=1 -> pc=0x0FC. Same with taken=0 -> pc=0x104.
- Jump: pc=0x1000_0000, JUMP, jaddr=0x0000040 -> pc=0x1000_0100. JREG with reg_target=0x400 -> pc=0x400.
- Exception: pc=0x200, exc_req=1 -> pc=0x80, epc=0x200, exl=1. A second exc_req -> ignored, pc=0x84. eret -> pc=0x200, exl=0.
- Halt: pc=0x40, halt=1 -> halted=1, pc=0x40 held for 5 cycles despite SEQ and exc_req. nRST pulse -> pc=0, halted=0.
- Wrap / alignment: pc=0xFFFF_FFFC, SEQ -> pc=0x0. JREG with reg_target=0x203:
  - with PC_ALIGN_CHK_EN -> align_fault=1, badvaddr=0x203, pc=0x80;
  - without it -> pc=0x200.
